// File: rtl/gt11clk_mon_pkg.sv
// Shared types and constants for the GT11 sync-clock monitor.
package gt11clk_mon_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    ON_PREF = 2'd1,
    ON_ALT  = 2'd2
  } sel_state_t;

  localparam logic SEL_SYNCLK1 = 1'b0;
  localparam logic SEL_SYNCLK2 = 1'b1;

endpackage

// File: rtl/gt11clk_edge_meter.sv
// Measures one chain clock's rising-edge rate per window and qualifies it
// after a run of consecutive in-range windows.
module gt11clk_edge_meter
  import gt11clk_mon_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int MIN_EDGES    = 200,
  parameter int MAX_EDGES    = 300,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             synclk,
  input  logic             window_end,
  output logic [CNT_W-1:0] count,
  output logic             ok
);

  localparam int RUN_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] LOCK_C  = RUN_W'(LOCK_WINDOWS);

  logic             s1, s2, s3;
  logic [1:0]       settle;
  logic             armed;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      cnt_ext;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;
  logic             good;

  // The synchronizer needs three clocks to fill after reset; edges seen
  // before that are artefacts of the flops' reset state.
  assign armed    = (settle == 2'd3);
  assign edge_det = armed & s2 & ~s3;

  assign cnt_inc = (edge_det && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;
  assign cnt_ext = 32'(cnt_inc);
  assign good    = (cnt_ext >= 32'(MIN_EDGES)) && (cnt_ext <= 32'(MAX_EDGES));
  assign run_inc = (run == LOCK_C) ? run : run + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      settle <= 2'd0;
      cnt    <= '0;
      count  <= '0;
      run    <= '0;
      ok     <= 1'b0;
    end else begin
      s1 <= synclk;
      s2 <= s1;
      s3 <= s2;
      if (!armed) settle <= settle + 2'd1;
      if (window_end) begin
        count <= cnt_inc;
        cnt   <= '0;
        if (good) begin
          run <= run_inc;
          ok  <= (run_inc == LOCK_C);
        end else begin
          run <= '0;
          ok  <= 1'b0;
        end
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/x_gt11clk_sync_monitor.sv
// Measures both GT11 chain clocks against CLK and selects the active sync
// clock, failing over to the alternate and optionally reverting.
module x_gt11clk_sync_monitor
  import gt11clk_mon_pkg::*;
#(
  parameter int WINDOW       = 1024,
  parameter int CNT_W        = 16,
  parameter int MIN_EDGES    = 200,
  parameter int MAX_EDGES    = 300,
  parameter int LOCK_WINDOWS = 4,
  parameter int PREFERRED    = 0,
  parameter int REVERTIVE    = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SYNCLK1IN,
  input  logic             SYNCLK2IN,
  output logic             SYNCLK1_OK,
  output logic             SYNCLK2_OK,
  output logic             ACTIVE_SEL,
  output logic             SEL_VALID,
  output logic             SWITCH_PULSE,
  output logic [CNT_W-1:0] COUNT1,
  output logic [CNT_W-1:0] COUNT2,
  output logic             COUNT_VALID
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic PREF_SEL = (PREFERRED != 0) ? SEL_SYNCLK2 : SEL_SYNCLK1;
  localparam logic ALT_SEL  = ~PREF_SEL;

  logic [WIN_W-1:0] wcnt;
  logic             window_end;
  logic             pref_ok, alt_ok;
  logic             sel_d, pulse_d;
  sel_state_t       state, state_next;

  assign window_end = (wcnt == WIN_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wcnt        <= '0;
      COUNT_VALID <= 1'b0;
    end else begin
      wcnt        <= window_end ? '0 : wcnt + 1'b1;
      COUNT_VALID <= window_end;
    end
  end

  gt11clk_edge_meter #(
    .CNT_W(CNT_W), .MIN_EDGES(MIN_EDGES), .MAX_EDGES(MAX_EDGES),
    .LOCK_WINDOWS(LOCK_WINDOWS)
  ) u_meter1 (
    .clk(CLK), .rst(RST), .synclk(SYNCLK1IN), .window_end(window_end),
    .count(COUNT1), .ok(SYNCLK1_OK)
  );

  gt11clk_edge_meter #(
    .CNT_W(CNT_W), .MIN_EDGES(MIN_EDGES), .MAX_EDGES(MAX_EDGES),
    .LOCK_WINDOWS(LOCK_WINDOWS)
  ) u_meter2 (
    .clk(CLK), .rst(RST), .synclk(SYNCLK2IN), .window_end(window_end),
    .count(COUNT2), .ok(SYNCLK2_OK)
  );

  assign pref_ok = (PREF_SEL == SEL_SYNCLK2) ? SYNCLK2_OK : SYNCLK1_OK;
  assign alt_ok  = (PREF_SEL == SEL_SYNCLK2) ? SYNCLK1_OK : SYNCLK2_OK;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= NONE;
      ACTIVE_SEL   <= PREF_SEL;
      SEL_VALID    <= 1'b0;
      SWITCH_PULSE <= 1'b0;
    end else begin
      state        <= state_next;
      ACTIVE_SEL   <= sel_d;
      SEL_VALID    <= (state_next != NONE);
      SWITCH_PULSE <= pulse_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      NONE: begin
        if (pref_ok)     state_next = ON_PREF;
        else if (alt_ok) state_next = ON_ALT;
      end
      ON_PREF: begin
        if (!pref_ok) state_next = alt_ok ? ON_ALT : NONE;
      end
      ON_ALT: begin
        if (!alt_ok)                          state_next = pref_ok ? ON_PREF : NONE;
        else if ((REVERTIVE != 0) && pref_ok) state_next = ON_PREF;
      end
      default: state_next = NONE;
    endcase
  end

  // Only a direct hop between the two sources counts as a switch; leaving
  // or entering NONE is a loss or acquisition, not a failover.
  always_comb begin
    sel_d   = ACTIVE_SEL;
    pulse_d = 1'b0;
    case (state_next)
      ON_PREF: sel_d = PREF_SEL;
      ON_ALT:  sel_d = ALT_SEL;
      default: sel_d = ACTIVE_SEL;
    endcase
    if ((state == ON_PREF && state_next == ON_ALT) ||
        (state == ON_ALT && state_next == ON_PREF))
      pulse_d = 1'b1;
  end

endmodule

// File: tb/tb_x_gt11clk_sync_monitor.sv
// Directed bench for the sync-clock monitor: three instances (revertive,
// non-revertive, 4-bit counters) share stimulus and are checked every cycle.
module tb_x_gt11clk_sync_monitor;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SYNCLK1IN = 1'b0;
  logic SYNCLK2IN = 1'b0;

  logic        ok1 [3];
  logic        ok2 [3];
  logic        sel [3];
  logic        valid [3];
  logic        pulse [3];
  logic        cv [3];
  logic [15:0] c1a, c2a, c1b, c2b;
  logic [3:0]  c1s, c2s;
  logic [37:0] actVec [3];

  int checks = 0;
  int errors = 0;
  int per1 = 4, per2 = 4;
  int ph1 = 0, ph2 = 0;
  int pulseSeen [3] = '{0, 0, 0};

  // Behavioural model state: window edge totals are unbounded integers and
  // saturation is applied only when reporting.
  int  mk;
  bit  hist [2][4];
  int  acc [2];
  bit  xin [2];
  int  mcount [3][2];
  int  run [3][2];
  bit  mok [3][2];
  int  mode [3];
  bit  msel [3], mvalid [3], mpulse [3];
  bit  mcv;
  int  cmax [3] = '{65535, 65535, 15};
  bit  rev [3]  = '{1'b1, 1'b0, 1'b1};

  always #5 CLK = ~CLK;

  x_gt11clk_sync_monitor #(.WINDOW(64), .CNT_W(16), .MIN_EDGES(12), .MAX_EDGES(20),
    .LOCK_WINDOWS(2), .PREFERRED(0), .REVERTIVE(1)) u_rev (
    .CLK(CLK), .RST(RST), .SYNCLK1IN(SYNCLK1IN), .SYNCLK2IN(SYNCLK2IN),
    .SYNCLK1_OK(ok1[0]), .SYNCLK2_OK(ok2[0]), .ACTIVE_SEL(sel[0]), .SEL_VALID(valid[0]),
    .SWITCH_PULSE(pulse[0]), .COUNT1(c1a), .COUNT2(c2a), .COUNT_VALID(cv[0]));

  x_gt11clk_sync_monitor #(.WINDOW(64), .CNT_W(16), .MIN_EDGES(12), .MAX_EDGES(20),
    .LOCK_WINDOWS(2), .PREFERRED(0), .REVERTIVE(0)) u_norev (
    .CLK(CLK), .RST(RST), .SYNCLK1IN(SYNCLK1IN), .SYNCLK2IN(SYNCLK2IN),
    .SYNCLK1_OK(ok1[1]), .SYNCLK2_OK(ok2[1]), .ACTIVE_SEL(sel[1]), .SEL_VALID(valid[1]),
    .SWITCH_PULSE(pulse[1]), .COUNT1(c1b), .COUNT2(c2b), .COUNT_VALID(cv[1]));

  x_gt11clk_sync_monitor #(.WINDOW(64), .CNT_W(4), .MIN_EDGES(12), .MAX_EDGES(20),
    .LOCK_WINDOWS(2), .PREFERRED(0), .REVERTIVE(1)) u_sat (
    .CLK(CLK), .RST(RST), .SYNCLK1IN(SYNCLK1IN), .SYNCLK2IN(SYNCLK2IN),
    .SYNCLK1_OK(ok1[2]), .SYNCLK2_OK(ok2[2]), .ACTIVE_SEL(sel[2]), .SEL_VALID(valid[2]),
    .SWITCH_PULSE(pulse[2]), .COUNT1(c1s), .COUNT2(c2s), .COUNT_VALID(cv[2]));

  assign actVec[0] = {ok1[0], ok2[0], sel[0], valid[0], pulse[0], cv[0], c1a, c2a};
  assign actVec[1] = {ok1[1], ok2[1], sel[1], valid[1], pulse[1], cv[1], c1b, c2b};
  assign actVec[2] = {ok1[2], ok2[2], sel[2], valid[2], pulse[2], cv[2],
                      12'd0, c1s, 12'd0, c2s};

  // Chain-clock generators: period in CLK cycles, 0 holds the clock low.
  always @(negedge CLK) begin
    if (per1 == 0) begin ph1 = 0; SYNCLK1IN = 1'b0; end
    else begin ph1 = (ph1 + 1) % per1; SYNCLK1IN = (ph1 < per1 / 2); end
    if (per2 == 0) begin ph2 = 0; SYNCLK2IN = 1'b0; end
    else begin ph2 = (ph2 + 1) % per2; SYNCLK2IN = (ph2 < per2 / 2); end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int p1, input int p2, input int cycles);
    @(negedge CLK);
    per1 = p1;
    per2 = p2;
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  function automatic logic [37:0] expVec(input int i);
    return {mok[i][0], mok[i][1], msel[i], mvalid[i], mpulse[i], mcv,
            16'(mcount[i][0]), 16'(mcount[i][1])};
  endfunction

  // Model step on every CLK edge, then compare all three instances.
  always @(posedge CLK) begin
    xin[0] = SYNCLK1IN;
    xin[1] = SYNCLK2IN;
    if (RST) begin
      mk  = 0;
      mcv = 1'b0;
      for (int c = 0; c < 2; c++) begin
        acc[c] = 0;
        for (int j = 0; j < 4; j++) hist[c][j] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 2; c++) begin
          mcount[i][c] = 0; run[i][c] = 0; mok[i][c] = 1'b0;
        end
        mode[i] = 0; msel[i] = 1'b0; mvalid[i] = 1'b0; mpulse[i] = 1'b0;
      end
    end else begin
      mk++;
      // Selection reacts to the qualification published on the previous edge.
      for (int i = 0; i < 3; i++) begin
        int nm;
        nm = mode[i];
        if (mode[i] == 0) nm = mok[i][0] ? 1 : (mok[i][1] ? 2 : 0);
        else if (mode[i] == 1) begin
          if (!mok[i][0]) nm = mok[i][1] ? 2 : 0;
        end else begin
          if (!mok[i][1]) nm = mok[i][0] ? 1 : 0;
          else if (rev[i] && mok[i][0]) nm = 1;
        end
        mpulse[i] = (mode[i] != 0) && (nm != 0) && (nm != mode[i]);
        mode[i]   = nm;
        mvalid[i] = (nm != 0);
        if (nm == 1) msel[i] = 1'b0;
        else if (nm == 2) msel[i] = 1'b1;
      end
      // An input rise sampled on edges k-3 -> k-2 is counted at edge k.
      for (int c = 0; c < 2; c++) begin
        for (int j = 3; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = xin[c];
        if (mk >= 4 && hist[c][2] && !hist[c][3]) acc[c]++;
      end
      mcv = (mk % 64 == 0);
      if (mcv) begin
        for (int i = 0; i < 3; i++)
          for (int c = 0; c < 2; c++) begin
            mcount[i][c] = (acc[c] > cmax[i]) ? cmax[i] : acc[c];
            if (mcount[i][c] >= 12 && mcount[i][c] <= 20)
              run[i][c] = (run[i][c] >= 2) ? 2 : run[i][c] + 1;
            else
              run[i][c] = 0;
            mok[i][c] = (run[i][c] >= 2);
          end
        acc[0] = 0;
        acc[1] = 0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("cycle_model_dut%0d_k%0d", i, mk), 64'(actVec[i]), 64'(expVec(i)));
      pulseSeen[i] += int'(pulse[i]);
    end
  end

  initial begin
    int p0;
    int n;
    bit found;

    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("reset_state_dut%0d", i), 64'(actVec[i]), 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Both chain clocks at 4 CLK period lock and land on the preferred source.
    applyStimulus(4, 4, 256);
    checkOutput("lock_count1", 64'(c1a), 64'd16);
    checkOutput("lock_count2", 64'(c2a), 64'd16);
    checkOutput("lock_oks", 64'({ok1[0], ok2[0]}), 64'd3);
    checkOutput("lock_sel_valid", 64'({sel[0], valid[0]}), 64'd1);
    checkOutput("lock_no_pulse", 64'(pulseSeen[0]), 64'd0);
    checkOutput("lock_sat_count1", 64'(c1s), 64'd15);

    // Stop clock 1: fail over to clock 2 with exactly one pulse.
    applyStimulus(0, 4, 200);
    checkOutput("stop1_count1", 64'(c1a), 64'd0);
    checkOutput("stop1_ok1", 64'(ok1[0]), 64'd0);
    checkOutput("stop1_sel", 64'({sel[0], valid[0]}), 64'd3);
    checkOutput("stop1_pulses_rev", 64'(pulseSeen[0]), 64'd1);
    checkOutput("stop1_pulses_norev", 64'(pulseSeen[1]), 64'd1);

    // Restart clock 1: revertive instance returns, non-revertive stays.
    applyStimulus(4, 4, 330);
    checkOutput("revert_ok1", 64'(ok1[0]), 64'd1);
    checkOutput("revert_sel_rev", 64'(sel[0]), 64'd0);
    checkOutput("revert_pulses_rev", 64'(pulseSeen[0]), 64'd2);
    checkOutput("revert_sel_norev", 64'(sel[1]), 64'd1);
    checkOutput("revert_pulses_norev", 64'(pulseSeen[1]), 64'd1);

    // Clock 2 alone at 2 CLK period is too fast; 4-bit counters saturate.
    applyStimulus(0, 2, 330);
    checkOutput("fast_count2", 64'(c2a), 64'd32);
    checkOutput("fast_ok2", 64'(ok2[0]), 64'd0);
    checkOutput("fast_sel_valid", 64'(valid[0]), 64'd0);
    checkOutput("fast_sat_count2", 64'(c2s), 64'd15);

    // Slow clock 2 to 5 CLK period: in range, acquired from NONE silently.
    p0 = pulseSeen[0];
    applyStimulus(0, 5, 330);
    checkOutput("slow_count2_range", 64'((c2a == 16'd12) || (c2a == 16'd13)), 64'd1);
    checkOutput("slow_ok2", 64'(ok2[0]), 64'd1);
    checkOutput("slow_sel_valid", 64'({sel[0], valid[0]}), 64'd3);
    checkOutput("slow_no_pulse", 64'(pulseSeen[0] - p0), 64'd0);

    // One-cycle reset mid-window while locked.
    applyStimulus(0, 5, 20);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("midrst_state", 64'(actVec[0]), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    // The cycle in which reset is released counts as cycle 1.
    n = 1;
    found = 1'b0;
    for (int j = 0; j < 200 && !found; j++) begin
      @(posedge CLK);
      #1;
      n++;
      if (cv[0]) found = 1'b1;
    end
    checkOutput("midrst_first_count_valid", found ? 64'(n) : 64'd0, 64'd65);

    applyStimulus(4, 5, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
